// File: rtl/ps2_mouse_pkg.sv
// Shared constants for the PS/2 mouse tracker: byte0 bit positions,
// button indices and the packet FSM state encoding.
package ps2_mouse_pkg;

   localparam int SYNC  = 3;
   localparam int XSIGN = 4;
   localparam int YSIGN = 5;
   localparam int XOVF  = 6;
   localparam int YOVF  = 7;

   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_MIDDLE = 2;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      COLLECT = 2'd1,
      APPLY   = 2'd2
   } state_t;

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: scales a 9-bit signed delta, adds or subtracts it at full
// width and clamps the result into [MIN, MAX].
module ps2_axis_accum
   import ps2_mouse_pkg::*;
#(
   parameter int W     = 11,
   parameter int MIN   = 0,
   parameter int MAX   = 639,
   parameter int INIT  = 320,
   parameter int SHIFT = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [8:0]   delta,
   input  logic         apply,
   input  logic         negate,
   input  logic         recenter,
   output logic [W-1:0] coord
);

   localparam int SW = W + SHIFT + 2;
   localparam logic signed [SW-1:0] MIN_S = SW'(MIN);
   localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

   logic signed [SW-1:0] d_s;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] clamped;

   // Two guard bits above the scaled delta keep the sum from wrapping before the clamp.
   always_comb begin
      d_s     = SW'(signed'(delta)) <<< SHIFT;
      sum     = SW'(signed'(coord)) + (negate ? -d_s : d_s);
      clamped = sum;
      if (sum < MIN_S)
         clamped = MIN_S;
      else if (sum > MAX_S)
         clamped = MAX_S;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         coord <= W'(INIT);
      else if (recenter)
         coord <= W'(INIT);
      else if (apply)
         coord <= W'(clamped);
   end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet assembler (3-byte or 4-byte wheel mode) with sync check,
// timeout resync, clamped cursor, button levels/edges and wheel delta.
module ps2_mouse_tracker
   import ps2_mouse_pkg::*;
#(
   parameter int COORD_W        = 11,
   parameter int X_MIN          = 0,
   parameter int X_MAX          = 639,
   parameter int Y_MIN          = 0,
   parameter int Y_MAX          = 479,
   parameter int X_INIT         = 320,
   parameter int Y_INIT         = 240,
   parameter int PACKET_BYTES   = 3,
   parameter int SHIFT          = 0,
   parameter int INVERT_Y       = 1,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_data_en,
   input  logic               recenter,
   output logic [COORD_W-1:0] cursor_x,
   output logic [COORD_W-1:0] cursor_y,
   output logic [2:0]         buttons,
   output logic [2:0]         btn_press,
   output logic [2:0]         btn_release,
   output logic [7:0]         wheel_delta,
   output logic               packet_valid,
   output logic [7:0]         sync_err_cnt
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]      LAST_IDX = 2'(PACKET_BYTES - 1);

   state_t          state, next;
   logic [7:0]      pkt [0:3];
   logic [1:0]      idx;
   logic [TO_W-1:0] tcnt;
   logic            take_b0, take_byte, drop_b0, expire, apply;
   logic [8:0]      dx, dy;
   logic [2:0]      new_btn;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         state <= WAIT_B0;
      else
         state <= next;
   end

   // APPLY treats an incoming byte exactly like WAIT_B0 so back-to-back packets survive.
   always_comb begin
      next      = state;
      take_b0   = 1'b0;
      take_byte = 1'b0;
      drop_b0   = 1'b0;
      expire    = 1'b0;
      case (state)
         WAIT_B0, APPLY: begin
            next = WAIT_B0;
            if (rx_data_en) begin
               if (rx_data[SYNC]) begin
                  take_b0 = 1'b1;
                  next    = COLLECT;
               end else begin
                  drop_b0 = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (rx_data_en) begin
               take_byte = 1'b1;
               if (idx == LAST_IDX)
                  next = APPLY;
            end else if (tcnt == TO_LAST) begin
               expire = 1'b1;
               next   = WAIT_B0;
            end
         end
         default: next = WAIT_B0;
      endcase
   end

   assign apply   = (state == APPLY);
   assign new_btn = pkt[0][BTN_MIDDLE:BTN_LEFT];
   assign dx      = pkt[0][XOVF] ? '0 : {pkt[0][XSIGN], pkt[1]};
   assign dy      = pkt[0][YOVF] ? '0 : {pkt[0][YSIGN], pkt[2]};

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 4; i++)
            pkt[i] <= '0;
         idx          <= '0;
         tcnt         <= '0;
         sync_err_cnt <= '0;
         buttons      <= '0;
         btn_press    <= '0;
         btn_release  <= '0;
         wheel_delta  <= '0;
         packet_valid <= 1'b0;
      end else begin
         if (take_b0) begin
            pkt[0] <= rx_data;
            idx    <= 2'd1;
         end else if (take_byte) begin
            pkt[idx] <= rx_data;
            idx      <= idx + 2'd1;
         end
         tcnt <= (state == COLLECT && !rx_data_en && !expire) ? tcnt + 1'b1 : '0;
         if ((drop_b0 || expire) && sync_err_cnt != 8'hFF)
            sync_err_cnt <= sync_err_cnt + 8'd1;
         packet_valid <= apply;
         btn_press    <= apply ? (new_btn & ~buttons) : '0;
         btn_release  <= apply ? (~new_btn & buttons) : '0;
         if (apply) begin
            buttons     <= new_btn;
            wheel_delta <= (PACKET_BYTES == 4) ? pkt[3] : '0;
         end
      end
   end

   ps2_axis_accum #(
      .W(COORD_W), .MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT), .SHIFT(SHIFT)
   ) u_x (
      .clk(CLOCK_50), .rst(reset), .delta(dx), .apply(apply),
      .negate(1'b0), .recenter(recenter), .coord(cursor_x)
   );

   ps2_axis_accum #(
      .W(COORD_W), .MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT), .SHIFT(SHIFT)
   ) u_y (
      .clk(CLOCK_50), .rst(reset), .delta(dy), .apply(apply),
      .negate(INVERT_Y != 0), .recenter(recenter), .coord(cursor_y)
   );

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: a 3-byte and a 4-byte instance driven with
// directed and random packets, checked against a packet-level cursor model.
module tb_ps2_mouse_tracker;

   localparam int XI = 320, YI = 240, XL = 0, XH = 639, YL = 0, YH = 479;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [7:0]  rx_data  [2];
   logic        rx_en    [2];
   logic        recenter [2];
   logic [10:0] cx [2];
   logic [10:0] cy [2];
   logic [2:0]  btn [2];
   logic [2:0]  bp  [2];
   logic [2:0]  br  [2];
   logic [7:0]  wd  [2];
   logic [7:0]  se  [2];
   logic        pv  [2];

   int total = 0, bad = 0;

   int         mx [2], my [2], mse [2];
   logic [2:0] mb [2], ep [2], er [2];
   logic [7:0] mwd [2];

   ps2_mouse_tracker u_dut3 (
      .CLOCK_50(clk), .reset(reset), .rx_data(rx_data[0]), .rx_data_en(rx_en[0]),
      .recenter(recenter[0]), .cursor_x(cx[0]), .cursor_y(cy[0]), .buttons(btn[0]),
      .btn_press(bp[0]), .btn_release(br[0]), .wheel_delta(wd[0]),
      .packet_valid(pv[0]), .sync_err_cnt(se[0])
   );

   ps2_mouse_tracker #(.PACKET_BYTES(4)) u_dut4 (
      .CLOCK_50(clk), .reset(reset), .rx_data(rx_data[1]), .rx_data_en(rx_en[1]),
      .recenter(recenter[1]), .cursor_x(cx[1]), .cursor_y(cy[1]), .buttons(btn[1]),
      .btn_press(bp[1]), .btn_release(br[1]), .wheel_delta(wd[1]),
      .packet_valid(pv[1]), .sync_err_cnt(se[1])
   );

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic int to_delta(input logic sgn, input logic [7:0] mag, input logic ovf);
      if (ovf) return 0;
      return sgn ? int'(mag) - 256 : int'(mag);
   endfunction

   task automatic model_apply(input int u, input logic [7:0] b0, b1, b2, b3, input bit rc);
      mx[u] = clamp(mx[u] + to_delta(b0[4], b1, b0[6]), XL, XH);
      my[u] = clamp(my[u] - to_delta(b0[5], b2, b0[7]), YL, YH);
      if (rc) begin
         mx[u] = XI;
         my[u] = YI;
      end
      ep[u] = b0[2:0] & ~mb[u];
      er[u] = ~b0[2:0] & mb[u];
      mb[u] = b0[2:0];
      if (u == 1) mwd[u] = b3;
   endtask

   task automatic check_state(input int u, input bit pulse);
      check($sformatf("cursor_x%0d", u), $signed(cx[u]), mx[u]);
      check($sformatf("cursor_y%0d", u), $signed(cy[u]), my[u]);
      check($sformatf("buttons%0d", u), btn[u], mb[u]);
      check($sformatf("wheel%0d", u), wd[u], mwd[u]);
      check($sformatf("sync_err%0d", u), se[u], mse[u]);
      check($sformatf("pkt_valid%0d", u), pv[u], pulse);
      check($sformatf("press%0d", u), bp[u], pulse ? ep[u] : 3'b000);
      check($sformatf("release%0d", u), br[u], pulse ? er[u] : 3'b000);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input int u, input logic [7:0] b);
      rx_data[u] = b;
      rx_en[u]   = 1'b1;
      @(negedge clk);
      rx_en[u]   = 1'b0;
   endtask

   task automatic send_bad(input int u);
      logic [7:0] b;
      b = 8'($urandom);
      b[3] = 1'b0;
      send_byte(u, b);
      mse[u] = (mse[u] < 255) ? mse[u] + 1 : 255;
      check($sformatf("drop_err%0d", u), se[u], mse[u]);
   endtask

   task automatic recenter_idle(input int u);
      recenter[u] = 1'b1;
      @(negedge clk);
      recenter[u] = 1'b0;
      mx[u] = XI;
      my[u] = YI;
      check($sformatf("recenter_x%0d", u), $signed(cx[u]), mx[u]);
      check($sformatf("recenter_y%0d", u), $signed(cy[u]), my[u]);
   endtask

   task automatic do_packet(input int u, input logic [7:0] b0, b1, b2, b3,
                            input bit rc, input bit tail, input bit gaps);
      send_byte(u, b0);
      if (gaps) idle($urandom_range(0, 3));
      send_byte(u, b1);
      if (gaps) idle($urandom_range(0, 3));
      send_byte(u, b2);
      if (u == 1) begin
         if (gaps) idle($urandom_range(0, 3));
         send_byte(u, b3);
      end
      model_apply(u, b0, b1, b2, b3, rc && tail);
      if (tail) begin
         check($sformatf("pv_early%0d", u), pv[u], 1'b0);
         if (rc) recenter[u] = 1'b1;
         @(negedge clk);
         recenter[u] = 1'b0;
         check_state(u, 1'b1);
         @(negedge clk);
         check_state(u, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] b0, b1, b2, b3;
      int r;
      for (int i = 0; i < 2; i++) begin
         rx_data[i] = '0; rx_en[i] = 1'b0; recenter[i] = 1'b0;
         mx[i] = XI; my[i] = YI; mse[i] = 0;
         mb[i] = '0; ep[i] = '0; er[i] = '0; mwd[i] = '0;
      end
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) check_state(i, 1'b0);

      do_packet(0, 8'h08, 8'h10, 8'h05, 8'h00, 0, 1, 0);
      recenter_idle(0);
      do_packet(0, 8'h38, 8'hF0, 8'h02, 8'h00, 0, 1, 0);
      recenter_idle(0);
      do_packet(0, 8'h18, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      do_packet(0, 8'h18, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      recenter_idle(0);
      send_byte(0, 8'h00);
      mse[0]++;
      do_packet(0, 8'h09, 8'h00, 8'h00, 8'h00, 0, 1, 0);

      recenter_idle(0);
      send_byte(0, 8'h08);
      send_byte(0, 8'h10);
      idle(50005);
      mse[0]++;
      check("timeout_err", se[0], mse[0]);
      do_packet(0, 8'h08, 8'h00, 8'h00, 8'h00, 0, 1, 0);

      do_packet(0, 8'h48, 8'hFF, 8'h01, 8'h00, 0, 1, 0);
      do_packet(0, 8'h48, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
      do_packet(1, 8'h08, 8'h00, 8'h00, 8'hFE, 0, 1, 0);

      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 40; k++) begin
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            b0[3] = 1'b1;
            if ($urandom_range(0, 7) != 0) b0[7:6] = 2'b00;
            r = $urandom_range(0, 9);
            case (r)
               0: begin
                  send_bad(u);
                  do_packet(u, b0, b1, b2, b3, 0, 1, 1);
               end
               1: recenter_idle(u);
               2: begin
                  do_packet(u, b0, b1, b2, b3, 0, 0, 0);
                  b0 = 8'($urandom); b0[3] = 1'b1; b0[7:6] = 2'b00;
                  do_packet(u, b0, b2, b1, b3, 0, 1, 0);
               end
               3: do_packet(u, b0, b1, b2, b3, 1, 1, 1);
               default: do_packet(u, b0, b1, b2, b3, 0, 1, 1);
            endcase
         end
      end

      for (int k = 0; k < 260; k++) begin
         send_byte(1, 8'h00);
         mse[1] = (mse[1] < 255) ? mse[1] + 1 : 255;
      end
      check("sync_err_sat", se[1], mse[1]);
      check("sync_err_sat_255", se[1], 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
